// File: rtl/gcm_pkg.sv
// Shared types and constants for the GCM phase sequencer and its word FIFO.
package gcm_pkg;

    localparam int TEXT_W     = 289;
    localparam int KS_W       = 256;
    localparam int CTR_W      = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int DRAIN_GAP  = 2;

    // J0+1: the first block of every packet
    localparam logic [CTR_W-1:0] CTR_START = CTR_W'(2);

    // Phase code seen by the bypass stage, one-hot in the low three bits
    typedef logic [0:3] phase_t;
    localparam phase_t PH_NONE   = 4'd0;
    localparam phase_t PH_FIRST  = 4'd1;
    localparam phase_t PH_SECOND = 4'd2;
    localparam phase_t PH_INNER  = 4'd4;

    typedef struct packed {
        logic [TEXT_W-1:0] text;
        logic              sop;
        logic              eop;
    } word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIRST,
        ST_SECOND,
        ST_INNER,
        ST_DRAIN
    } out_st_t;

endpackage

// File: rtl/gcm_word_fifo.sv
// Synchronous FIFO of packet words waiting for their keystream.
// Count is registered so full/empty never depend on same-cycle push/pop.
module gcm_word_fifo
    import gcm_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
)(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_push,
    input  word_t i_data,
    input  logic  i_pop,
    output word_t o_head,
    output logic  o_full,
    output logic  o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    word_t          r_mem [DEPTH];
    logic [AW-1:0]  r_wr;
    logic [AW-1:0]  r_rd;
    logic [CW-1:0]  r_count;
    logic           w_push;
    logic           w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd];

    // Storage: data only, contents are meaningless until pushed
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/gcm_phase_sequencer.sv
// Tags packet words with FIRST/SECOND/INNER phase, issues one keystream
// request per word, pairs returned keystream with the buffered word and
// inserts the drain gap the bypass stage needs after every last word.
module gcm_phase_sequencer
    import gcm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic [TEXT_W-1:0] in_text,
    output logic              ks_req,
    output logic [CTR_W-1:0]  ks_ctr,
    input  logic              ks_valid,
    output logic              ks_ready,
    input  logic [KS_W-1:0]   ks_data,
    output phase_t            o_state,
    output logic              o_last,
    output logic [TEXT_W-1:0] o_text,
    output logic [KS_W-1:0]   o_cipher,
    output logic              o_ready,
    output logic              busy,
    output logic              err
);

    localparam int GAP_W = $clog2(DRAIN_GAP + 1);

    // Input side
    logic              w_push;
    logic              w_full;
    logic              w_empty;
    word_t             w_in_word;
    word_t             w_head;
    logic [CTR_W-1:0]  w_req_ctr;
    logic [CTR_W-1:0]  w_ctr_nxt;
    logic [CTR_W-1:0]  r_ctr;
    logic              r_ks_req;
    logic [CTR_W-1:0]  r_ks_ctr;
    logic              r_in_pkt;

    // Output side
    logic              w_pop;
    out_st_t           r_state;
    out_st_t           w_state_nxt;
    logic [GAP_W-1:0]  r_gap;
    logic [GAP_W-1:0]  w_gap_nxt;
    phase_t            w_code;
    logic              w_bad_head;
    logic              r_o_ready;
    logic              r_o_last;
    phase_t            r_o_state;
    logic [TEXT_W-1:0] r_o_text;
    logic [KS_W-1:0]   r_o_cipher;
    logic              r_err;

    assign w_in_word = '{text: in_text, sop: in_sop, eop: in_eop};
    assign in_ready  = !w_full;
    assign w_push    = in_valid && in_ready;
    assign ks_ready  = !w_empty && (r_state != ST_DRAIN);
    assign w_pop     = ks_valid && ks_ready;

    // A sop word always requests CTR_START; the counter then points past both blocks
    assign w_req_ctr = in_sop ? CTR_START : r_ctr;
    assign w_ctr_nxt = w_req_ctr + CTR_W'(2);

    gcm_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_in_word),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Counter and keystream request, one request per accepted word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctr    <= CTR_START;
            r_ks_req <= 1'b0;
            r_ks_ctr <= '0;
            r_in_pkt <= 1'b0;
        end else begin
            r_ks_req <= w_push;
            if (w_push) begin
                r_ks_ctr <= w_req_ctr;
                r_ctr    <= w_ctr_nxt;
                r_in_pkt <= !in_eop;
            end
        end
    end

    // Out FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gap   <= w_gap_nxt;
        end
    end

    // Out FSM next state and phase code; a non-sop head in IDLE restarts as FIRST
    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap;
        w_code      = PH_NONE;
        w_bad_head  = 1'b0;
        if (r_state == ST_DRAIN) begin
            if (r_gap == '0) w_state_nxt = ST_IDLE;
            else             w_gap_nxt   = r_gap - GAP_W'(1);
        end else if (w_pop) begin
            if (w_head.sop || r_state == ST_IDLE) begin
                w_code      = PH_FIRST;
                w_state_nxt = ST_FIRST;
                w_bad_head  = !w_head.sop;
            end else if (r_state == ST_FIRST) begin
                w_code      = PH_SECOND;
                w_state_nxt = ST_SECOND;
            end else begin
                w_code      = PH_INNER;
                w_state_nxt = ST_INNER;
            end
            if (w_head.eop) begin
                w_state_nxt = ST_DRAIN;
                w_gap_nxt   = GAP_W'(DRAIN_GAP - 1);
            end
        end
    end

    // Bypass-stage outputs: strobes clear when idle, data holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_o_ready  <= 1'b0;
            r_o_last   <= 1'b0;
            r_o_state  <= PH_NONE;
            r_o_text   <= '0;
            r_o_cipher <= '0;
        end else begin
            r_o_ready <= w_pop;
            r_o_last  <= w_pop && w_head.eop;
            r_o_state <= w_code;
            if (w_pop) begin
                r_o_text   <= w_head.text;
                r_o_cipher <= ks_data;
            end
        end
    end

    // Sticky protocol error: sop inside an open input packet, or headless word at output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_err <= 1'b0;
        else     r_err <= r_err || (w_push && in_sop && r_in_pkt) || (w_pop && w_bad_head);
    end

    assign ks_req   = r_ks_req;
    assign ks_ctr   = r_ks_ctr;
    assign o_ready  = r_o_ready;
    assign o_last   = r_o_last;
    assign o_state  = r_o_state;
    assign o_text   = r_o_text;
    assign o_cipher = r_o_cipher;
    assign busy     = !w_empty || (r_state == ST_DRAIN);
    assign err      = r_err;

endmodule

// File: tb/tb_gcm_phase_sequencer.sv
// Bench for gcm_phase_sequencer: packet-level model plus directed packets.
module tb_gcm_phase_sequencer;
    import gcm_pkg::*;

    typedef logic [31:0] u32_q [$];

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_sop;
    logic              in_eop;
    logic [TEXT_W-1:0] in_text;
    logic              ks_req;
    logic [CTR_W-1:0]  ks_ctr;
    logic              ks_valid;
    logic              ks_ready;
    logic [KS_W-1:0]   ks_data;
    phase_t            o_state;
    logic              o_last;
    logic [TEXT_W-1:0] o_text;
    logic [KS_W-1:0]   o_cipher;
    logic              o_ready;
    logic              busy;
    logic              err;

    gcm_phase_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_eop(in_eop), .in_text(in_text),
        .ks_req(ks_req), .ks_ctr(ks_ctr), .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data),
        .o_state(o_state), .o_last(o_last), .o_text(o_text), .o_cipher(o_cipher), .o_ready(o_ready),
        .busy(busy), .err(err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Keystream changes every cycle so pairing mistakes are visible
    initial begin
        ks_data = '0;
        forever begin
            @(posedge clk);
            #1;
            ks_data = {$urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom(), $urandom()};
        end
    end

    // ---------------- packet-level model ----------------
    word_t             wq [$];
    word_t             mw;
    logic [31:0]       m_ctr;
    logic              m_inpkt, m_open;
    int                m_pos, m_gap;
    logic              e_req, e_ready, e_last, e_err;
    logic [31:0]       e_ctr;
    phase_t            e_state;
    logic [TEXT_W-1:0] e_text;
    logic [KS_W-1:0]   e_cipher;
    logic              x_in_ready, x_ks_ready, x_busy;
    logic              ovr_en;
    logic [31:0]       ovr_val;
    int                cyc;
    u32_q              ctr_log, st_log, cyc_log, txt_log;

    initial begin : monitor
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                wq.delete();
                m_ctr = 32'd2; m_inpkt = 0; m_open = 0; m_pos = 0; m_gap = 0;
                e_req = 0; e_ready = 0; e_last = 0; e_err = 0; e_ctr = 0;
                e_state = PH_NONE; e_text = '0; e_cipher = '0;
            end
            x_in_ready = (wq.size() != FIFO_DEPTH);
            x_ks_ready = (wq.size() != 0) && (m_gap == 0);
            x_busy     = (wq.size() != 0) || (m_gap > 0);
            chk("in_ready", in_ready, x_in_ready);
            chk("ks_ready", ks_ready, x_ks_ready);
            chk("busy", busy, x_busy);
            chk("err", err, e_err);
            chk("ks_req", ks_req, e_req);
            if (e_req) chk("ks_ctr", ks_ctr, e_ctr);
            chk("o_ready", o_ready, e_ready);
            chk("o_state", o_state, e_state);
            chk("o_last", o_last, e_last);
            chk("o_text", o_text, e_text);
            chk("o_cipher", o_cipher, e_cipher);
            if (ks_req) ctr_log.push_back(ks_ctr);
            if (o_ready) begin
                st_log.push_back({27'd0, o_last, o_state});
                cyc_log.push_back(cyc);
                txt_log.push_back({24'd0, o_text[7:0]});
            end
            if (!rst) begin
                if (m_gap > 0) m_gap--;
                e_ready = 0; e_last = 0; e_state = PH_NONE;
                if (ks_valid && x_ks_ready) begin
                    mw = wq.pop_front();
                    if (!mw.sop && !m_open) e_err = 1;
                    m_pos   = (mw.sop || !m_open) ? 0 : m_pos + 1;
                    e_state = (m_pos == 0) ? PH_FIRST : (m_pos == 1) ? PH_SECOND : PH_INNER;
                    e_ready = 1; e_last = mw.eop; e_text = mw.text; e_cipher = ks_data;
                    m_open  = !mw.eop;
                    if (mw.eop) m_gap = DRAIN_GAP;
                end
                e_req = 0;
                if (in_valid && x_in_ready) begin
                    if (in_sop && m_inpkt) e_err = 1;
                    e_req   = 1;
                    e_ctr   = in_sop ? 32'd2 : m_ctr;
                    m_ctr   = ovr_en ? ovr_val : (in_sop ? 32'd4 : m_ctr + 32'd2);
                    m_inpkt = !in_eop;
                    mw = '{text: in_text, sop: in_sop, eop: in_eop};
                    wq.push_back(mw);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [TEXT_W-1:0] mk_text(input logic [7:0] id);
        logic [TEXT_W-1:0] t;
        t = '0;
        t[7:0] = id;
        t[150 +: 32] = $urandom();
        t[TEXT_W-1 -: 8] = ~id;
        return t;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic s, input logic e, input logic [7:0] id);
        logic acc;
        int   n;
        acc = 0; n = 0;
        in_valid = 1; in_sop = s; in_eop = e; in_text = mk_text(id);
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 0; in_sop = 0; in_eop = 0;
    endtask

    task automatic exp_list(input string nm, input u32_q q, input int mark, input u32_q ex);
        chk({nm, "_count"}, q.size() - mark, ex.size());
        foreach (ex[i]) chk($sformatf("%s_%0d", nm, i), q[mark + i], ex[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    int mc, ms, mt;

    initial begin
        rst = 1; in_valid = 0; in_sop = 0; in_eop = 0; in_text = '0; ks_valid = 0;
        ovr_en = 0; ovr_val = 0;
        step(3);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_o_ready", o_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        rst = 0;

        // 1: three-word packet, keystream always available
        ks_valid = 1;
        mc = ctr_log.size(); ms = st_log.size();
        send(1, 0, 8'h11); send(0, 0, 8'h12); send(0, 1, 8'h13);
        step(8);
        exp_list("t1_ctr", ctr_log, mc, '{32'd2, 32'd4, 32'd6});
        exp_list("t1_state", st_log, ms, '{32'd1, 32'd2, 32'd20});

        // 2: single-word packets back to back
        ms = st_log.size();
        send(1, 1, 8'h21); send(1, 1, 8'h22);
        step(8);
        exp_list("t2_state", st_log, ms, '{32'd17, 32'd17});
        chk("t2_gap_ok", (cyc_log[ms + 1] - cyc_log[ms]) >= DRAIN_GAP + 1, 1);

        // 3: keystream stalled, FIFO fills, then drains in order
        ks_valid = 0;
        ms = st_log.size(); mt = txt_log.size();
        send(1, 0, 8'h31); send(0, 0, 8'h32); send(0, 0, 8'h33); send(0, 0, 8'h34);
        in_valid = 1; in_text = mk_text(8'h35);
        repeat (3) begin
            @(negedge clk);
            chk("t3_full_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        ks_valid = 1;
        send(0, 0, 8'h35); send(0, 1, 8'h36);
        step(12);
        exp_list("t3_state", st_log, ms, '{32'd1, 32'd2, 32'd4, 32'd4, 32'd4, 32'd20});
        exp_list("t3_text", txt_log, mt, '{32'h31, 32'h32, 32'h33, 32'h34, 32'h35, 32'h36});

        // 4: counter wraps past 2^32 without stalling
        mc = ctr_log.size();
        ovr_en = 1; ovr_val = 32'hFFFF_FFFC;
        force dut.w_ctr_nxt = 32'hFFFF_FFFC;
        send(1, 0, 8'h41);
        release dut.w_ctr_nxt;
        ovr_en = 0;
        send(0, 0, 8'h42); send(0, 0, 8'h43); send(0, 1, 8'h44);
        step(8);
        exp_list("t4_ctr", ctr_log, mc, '{32'd2, 32'hFFFF_FFFC, 32'hFFFF_FFFE, 32'h0});

        // 5: second packet right behind the first eop
        mc = ctr_log.size(); ms = st_log.size();
        send(1, 0, 8'h51); send(0, 1, 8'h52); send(1, 0, 8'h53); send(0, 1, 8'h54);
        step(10);
        exp_list("t5_ctr", ctr_log, mc, '{32'd2, 32'd4, 32'd2, 32'd4});
        exp_list("t5_state", st_log, ms, '{32'd1, 32'd18, 32'd1, 32'd18});
        chk("t5_gap_ok", (cyc_log[ms + 2] - cyc_log[ms + 1]) >= DRAIN_GAP + 1, 1);
        chk("t5_err_clean", err, 0);

        // 7: protocol errors: sop inside a packet, then a headless word
        ms = st_log.size();
        send(1, 0, 8'h71); send(1, 1, 8'h72);
        step(6);
        chk("t7_err_sop", err, 1);
        send(0, 1, 8'h73);
        step(6);
        exp_list("t7_state", st_log, ms, '{32'd1, 32'd17, 32'd17});
        chk("t7_err_sticky", err, 1);

        // 6: reset while a word is being handed over
        send(1, 0, 8'h61); send(0, 0, 8'h62);
        rst = 1;
        #1;
        chk("t6_o_ready", o_ready, 0);
        chk("t6_o_state", o_state, 0);
        chk("t6_ks_ready", ks_ready, 0);
        chk("t6_busy", busy, 0);
        chk("t6_err", err, 0);
        step(2);
        rst = 0;
        #1;
        chk("t6_in_ready", in_ready, 1);
        mc = ctr_log.size(); ms = st_log.size();
        send(1, 1, 8'h63);
        step(6);
        exp_list("t6_ctr", ctr_log, mc, '{32'd2});
        exp_list("t6_state", st_log, ms, '{32'd17});
        chk("t6_err_after", err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
